// File: rtl/uart_pkg.sv
// Shared UART/ALU definitions: default widths, sequencer state encoding and ALU opcodes.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int OP_WIDTH_DEF   = 6;

   localparam logic [2:0] ST_WAIT_A  = 3'd0;
   localparam logic [2:0] ST_WAIT_B  = 3'd1;
   localparam logic [2:0] ST_WAIT_OP = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   typedef enum logic [2:0] {
      S_WAIT_A  = ST_WAIT_A,
      S_WAIT_B  = ST_WAIT_B,
      S_WAIT_OP = ST_WAIT_OP,
      S_EXEC    = ST_EXEC,
      S_SEND    = ST_SEND,
      S_WAIT_TX = ST_WAIT_TX
   } seq_state_e;

   localparam logic [5:0] ALU_ADD = 6'b100000;
   localparam logic [5:0] ALU_SUB = 6'b100010;
   localparam logic [5:0] ALU_AND = 6'b100100;
   localparam logic [5:0] ALU_OR  = 6'b100101;
   localparam logic [5:0] ALU_XOR = 6'b100110;
   localparam logic [5:0] ALU_SRA = 6'b000011;
   localparam logic [5:0] ALU_SRL = 6'b000010;
   localparam logic [5:0] ALU_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_interface_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, flags the last allowed cycle.
module timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1000000,
   localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == TERMINAL);

endmodule

// File: rtl/uart_alu_interface.sv
// Sequencer between UART RX, ALU and UART TX: gathers A, B, opcode, runs the ALU
// for one cycle and hands the result to the transmitter.
//
// state      | meaning
// WAIT_A     | idle, waiting for operand A byte
// WAIT_B     | waiting for operand B byte (timeout armed)
// WAIT_OP    | waiting for opcode byte (timeout armed)
// EXEC       | one cycle for the ALU to settle, result captured
// SEND       | o_tx_start pulse
// WAIT_TX    | waiting for transmitter done
module uart_alu_interface
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int OP_WIDTH       = OP_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_rx_done,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic                  i_tx_done,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [DATA_WIDTH-1:0] o_alu_b,
   output logic [OP_WIDTH-1:0]   o_alu_op,
   output logic                  o_tx_start,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_busy,
   output logic                  o_timeout,
   output logic                  o_overrun
);

   seq_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  overrun_q, overrun_d;

   logic busy;
   logic tx_start;
   logic timeout_fire;
   logic cnt_clear;
   logic cnt_enable;
   logic cnt_expired;

   assign busy = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_WAIT_TX);

   timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .clear_i  (cnt_clear),
      .enable_i (cnt_enable),
      .expired_o(cnt_expired)
   );

   // A byte arriving on the expiry cycle takes priority over the timeout.
   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      tx_data_d    = tx_data_q;
      overrun_d    = overrun_q | (i_rx_done & busy);
      tx_start     = 1'b0;
      timeout_fire = 1'b0;
      cnt_clear    = 1'b1;
      cnt_enable   = 1'b0;

      case (state_q)
         S_WAIT_A: begin
            if (i_rx_done) begin
               alu_a_d = i_rx_data;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (i_rx_done) begin
               alu_b_d = i_rx_data;
               state_d = S_WAIT_OP;
            end else if (cnt_expired) begin
               timeout_fire = 1'b1;
               state_d      = S_WAIT_A;
            end else begin
               cnt_clear  = 1'b0;
               cnt_enable = 1'b1;
            end
         end
         S_WAIT_OP: begin
            if (i_rx_done) begin
               alu_op_d = i_rx_data[OP_WIDTH-1:0];
               state_d  = S_EXEC;
            end else if (cnt_expired) begin
               timeout_fire = 1'b1;
               state_d      = S_WAIT_A;
            end else begin
               cnt_clear  = 1'b0;
               cnt_enable = 1'b1;
            end
         end
         S_EXEC: begin
            tx_data_d = i_alu_result;
            state_d   = S_SEND;
         end
         S_SEND: begin
            tx_start = 1'b1;
            state_d  = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (i_tx_done) begin
               state_d = S_WAIT_A;
            end
         end
         default: begin
            state_d = S_WAIT_A;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= S_WAIT_A;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         tx_data_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         tx_data_q <= tx_data_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_alu_a    = alu_a_q;
   assign o_alu_b    = alu_b_q;
   assign o_alu_op   = alu_op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start;
   assign o_busy     = busy;
   assign o_timeout  = timeout_fire;
   assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface with a behavioural ALU and frame model.
module tb_uart_alu_interface;
   import uart_pkg::*;

   localparam int DW  = 8;
   localparam int OPW = 6;
   localparam int TMO = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rx_done = 1'b0;
   logic [DW-1:0]  rx_data = '0;
   logic [DW-1:0]  alu_result;
   logic           tx_done = 1'b0;
   logic [DW-1:0]  alu_a, alu_b, tx_data;
   logic [OPW-1:0] alu_op;
   logic           tx_start, busy, timeout, overrun;

   int checks = 0;
   int errors = 0;
   logic exp_overrun = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SRA: return 8'(sa >>> b);
         ALU_SRL: return a >> b;
         ALU_NOR: return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_ref(alu_a, alu_b, alu_op);

   uart_alu_interface #(
      .DATA_WIDTH(DW), .OP_WIDTH(OPW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
      .i_alu_result(alu_result), .i_tx_done(tx_done),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_tx_start(tx_start),
      .o_tx_data(tx_data), .o_busy(busy), .o_timeout(timeout), .o_overrun(overrun)
   );

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_overrun = 1'b0;
   endtask

   task automatic idle_no_timeout(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s_gap_timeout: got %b want 0", tag, timeout); end
      end
   endtask

   // Full frame with result check; optional overrun byte and tx_done delay in WAIT_TX.
   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input int gap, input int txd_delay, input bit inject, input string tag);
      logic [7:0] exp;
      int n;
      exp = alu_ref(a, b, opb[5:0]);
      send_byte(a);
      idle_no_timeout(gap, tag);
      send_byte(b);
      idle_no_timeout(gap, tag);
      send_byte(opb);
      checks++; if (alu_a !== a) begin errors++; $display("FAIL %s_alu_a: got %h want %h", tag, alu_a, a); end
      checks++; if (alu_b !== b) begin errors++; $display("FAIL %s_alu_b: got %h want %h", tag, alu_b, b); end
      checks++; if (alu_op !== opb[5:0]) begin errors++; $display("FAIL %s_alu_op: got %h want %h", tag, alu_op, opb[5:0]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_exec: got %b want 1", tag, busy); end
      n = 0;
      while (tx_start !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL %s_tx_start_latency: got %0d want 1 cycle after exec", tag, n); end
      checks++; if (tx_data !== exp) begin errors++; $display("FAIL %s_tx_data: got %h want %h", tag, tx_data, exp); end
      @(negedge clk);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL %s_tx_start_width: got %b want 0", tag, tx_start); end
      if (inject) begin
         rx_done = 1'b1;
         rx_data = 8'h77;
         @(negedge clk);
         rx_done = 1'b0;
         exp_overrun = 1'b1;
         checks++; if (alu_a !== a || alu_b !== b) begin errors++; $display("FAIL %s_overrun_latched: got a=%h b=%h want a=%h b=%h", tag, alu_a, alu_b, a, b); end
      end
      for (int i = 0; i < txd_delay; i++) begin
         checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin errors++; $display("FAIL %s_wait_tx: got busy=%b start=%b want 1/0", tag, busy, tx_start); end
         @(negedge clk);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_wait_tx: got %b want 1", tag, busy); end
      pulse_tx_done();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_after_tx: got busy=%b want 0", tag, busy); end
      checks++; if (tx_data !== exp) begin errors++; $display("FAIL %s_tx_data_hold: got %h want %h", tag, tx_data, exp); end
      checks++; if (overrun !== exp_overrun) begin errors++; $display("FAIL %s_overrun: got %b want %b", tag, overrun, exp_overrun); end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({alu_a, alu_b, alu_op, tx_data} !== '0) begin errors++; $display("FAIL reset_data: got a=%h b=%h op=%h tx=%h want 0", alu_a, alu_b, alu_op, tx_data); end
      checks++; if ({tx_start, busy, timeout, overrun} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {tx_start, busy, timeout, overrun}); end
   endtask

   task automatic test_basic_add();
      run_frame(8'h05, 8'h03, 8'h20, 0, 3, 1'b0, "basic_add");
      checks++; if (tx_data !== 8'h08) begin errors++; $display("FAIL basic_add_const: got %h want 08", tx_data); end
   endtask

   task automatic measure_timeout(input string tag);
      int first, pulses;
      first = -1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (timeout === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
         @(negedge clk);
      end
      checks++; if (first !== TMO - 1) begin errors++; $display("FAIL %s_when: got cycle %0d want %0d", tag, first, TMO - 1); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL %s_pulses: got %0d want 1", tag, pulses); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
   endtask

   task automatic test_timeout();
      do_reset();
      send_byte(8'h0F);
      measure_timeout("timeout_b");
      checks++; if (alu_a !== 8'h0F) begin errors++; $display("FAIL timeout_stale_a: got %h want 0f", alu_a); end
      run_frame(8'hF0, 8'h0F, 8'h24, 2, 1, 1'b0, "after_timeout_and");
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL after_timeout_and_const: got %h want 00", tx_data); end
      send_byte(8'h33);
      send_byte(8'h44);
      measure_timeout("timeout_op");
      checks++; if (alu_b !== 8'h44) begin errors++; $display("FAIL timeout_stale_b: got %h want 44", alu_b); end
      run_frame(8'h12, 8'h34, 8'h25, 1, 0, 1'b0, "after_timeout_or");
   endtask

   task automatic test_collision();
      int n;
      do_reset();
      send_byte(8'h0A);
      repeat (TMO - 1) @(negedge clk);
      rx_done = 1'b1;
      rx_data = 8'h01;
      #1;
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL collision_timeout: got %b want 0", timeout); end
      @(negedge clk);
      rx_done = 1'b0;
      checks++; if (alu_b !== 8'h01) begin errors++; $display("FAIL collision_alu_b: got %h want 01", alu_b); end
      checks++; if (alu_a !== 8'h0A || busy !== 1'b0) begin errors++; $display("FAIL collision_state: got a=%h busy=%b want 0a/0", alu_a, busy); end
      send_byte(8'h20);
      n = 0;
      while (tx_start !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 1 || tx_data !== 8'h0B) begin errors++; $display("FAIL collision_wait_op: got latency %0d data %h want 1/0b", n, tx_data); end
      pulse_tx_done();
   endtask

   task automatic test_overrun();
      do_reset();
      run_frame(8'h21, 8'h13, 8'h26, 0, 2, 1'b1, "overrun_frame");
      run_frame(8'h09, 8'h04, 8'h22, 0, 1, 1'b0, "overrun_sub");
      checks++; if (tx_data !== 8'h05 || overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got data=%h ovr=%b want 05/1", tx_data, overrun); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_byte(8'h11);
      send_byte(8'h22);
      do_reset();
      checks++; if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun} !== '0) begin errors++; $display("FAIL reset_mid: got a=%h b=%h busy=%b want 0", alu_a, alu_b, busy); end
      run_frame(8'hFF, 8'h01, 8'h20, 0, 0, 1'b0, "wrap_add");
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL wrap_add_const: got %h want 00", tx_data); end
   endtask

   task automatic test_spurious_tx_done();
      do_reset();
      pulse_tx_done();
      checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL spurious_a: got busy=%b start=%b want 0/0", busy, tx_start); end
      send_byte(8'h6C);
      pulse_tx_done();
      checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || alu_a !== 8'h6C) begin errors++; $display("FAIL spurious_b: got busy=%b start=%b a=%h want 0/0/6c", busy, tx_start, alu_a); end
      send_byte(8'h05);
      send_byte(8'h26);
      repeat (1) @(negedge clk);
      checks++; if (tx_start !== 1'b1 || tx_data !== 8'h69) begin errors++; $display("FAIL spurious_frame: got start=%b data=%h want 1/69", tx_start, tx_data); end
      pulse_tx_done();
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      logic [7:0] opb;
      ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SRA, ALU_SRL, ALU_NOR};
      do_reset();
      for (int f = 0; f < 25; f++) begin
         if ($urandom_range(0, 7) == 0) opb = 8'($urandom);
         else opb = {2'($urandom), ops[$urandom_range(0, 7)]};
         run_frame(8'($urandom), 8'($urandom_range(0, 9)), opb, $urandom_range(0, TMO - 4),
                   $urandom_range(0, 5), ($urandom_range(0, 5) == 0), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_timeout();
      test_collision();
      test_overrun();
      test_reset_mid();
      test_spurious_tx_done();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
